// File: rtl/frame_aligner_if.sv
// Serial-in / aligned-word-out bundle for frame_aligner.
// master drives the line side; slave is the aligner.
interface frame_aligner_if;
    logic        bit_en;
    logic        data_in;
    logic [31:0] data_out;
    logic        data_valid;
    logic        frame_start;
    logic        locked;
    logic        sync_err;
    logic [15:0] err_count;

    modport master (
        output bit_en, data_in,
        input  data_out, data_valid, frame_start, locked, sync_err, err_count
    );

    modport slave (
        input  bit_en, data_in,
        output data_out, data_valid, frame_start, locked, sync_err, err_count
    );
endinterface

// File: rtl/frame_aligner.sv
// Serial frame aligner: hunts for SYNC_WORD, verifies, then emits aligned payload words.
// Optional saturating sync-error counter enabled by FRAME_ALIGNER_ERR_CNT_EN.
module frame_aligner #(
    parameter logic [31:0] SYNC_WORD   = 32'hA5A5_5AF0,
    parameter int unsigned FRAME_WORDS = 8,
    parameter int unsigned LOCK_CNT    = 2,
    parameter int unsigned UNLOCK_CNT  = 3
) (
    input  logic           clk,
    input  logic           rst,
    frame_aligner_if.slave bus
);
    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_VERIFY  = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;
    localparam logic [4:0] LAST_BIT   = 5'd31;
    localparam logic [7:0] LAST_WORD  = 8'(FRAME_WORDS);
    localparam logic [3:0] LOCK_TGT   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_TGT = 4'(UNLOCK_CNT);

    logic [1:0]  r_state, w_state;
    logic [31:0] r_sh;
    logic [4:0]  r_bit_cnt, w_bit_cnt;
    logic [7:0]  r_word_cnt, w_word_cnt;
    logic [3:0]  r_good_cnt, w_good_cnt;
    logic [3:0]  r_bad_cnt, w_bad_cnt;
    logic [31:0] r_data_out, w_data_out;
    logic        r_data_valid, w_data_valid;
    logic        r_frame_start, w_frame_start;
    logic        r_sync_err, w_sync_err;
    logic        r_locked;
    logic [31:0] w_cand;
    logic        w_hit, w_word_end, w_slot_end;

    assign w_cand     = {r_sh[30:0], bus.data_in};
    assign w_hit      = (w_cand == SYNC_WORD);
    assign w_word_end = (r_bit_cnt == LAST_BIT);
    assign w_slot_end = w_word_end && (r_word_cnt == 8'd0);

    always_comb begin
        w_state       = r_state;
        w_bit_cnt     = r_bit_cnt;
        w_word_cnt    = r_word_cnt;
        w_good_cnt    = r_good_cnt;
        w_bad_cnt     = r_bad_cnt;
        w_data_out    = r_data_out;
        w_data_valid  = 1'b0;
        w_frame_start = 1'b0;
        w_sync_err    = 1'b0;
        if (bus.bit_en) begin
            if (r_state == ST_HUNT) begin
                if (w_hit) begin
                    // Next bit is bit 0 of payload word 1.
                    w_bit_cnt  = 5'd0;
                    w_word_cnt = 8'd1;
                    w_good_cnt = 4'd1;
                    w_bad_cnt  = 4'd0;
                    w_state    = (LOCK_TGT == 4'd1) ? ST_LOCKED : ST_VERIFY;
                end
            end else begin
                if (w_word_end) begin
                    w_bit_cnt  = 5'd0;
                    w_word_cnt = (r_word_cnt == LAST_WORD) ? 8'd0 : r_word_cnt + 8'd1;
                end else begin
                    w_bit_cnt = r_bit_cnt + 5'd1;
                end

                if (r_state == ST_VERIFY) begin
                    if (w_slot_end) begin
                        if (w_hit) begin
                            w_good_cnt = r_good_cnt + 4'd1;
                            if (w_good_cnt == LOCK_TGT) begin
                                w_state   = ST_LOCKED;
                                w_bad_cnt = 4'd0;
                            end
                        end else begin
                            w_state    = ST_HUNT;
                            w_good_cnt = 4'd0;
                        end
                    end
                end else if (r_state == ST_LOCKED) begin
                    if (w_slot_end) begin
                        if (w_hit) begin
                            w_bad_cnt = 4'd0;
                        end else begin
                            w_sync_err = 1'b1;
                            w_bad_cnt  = r_bad_cnt + 4'd1;
                            if (w_bad_cnt == UNLOCK_TGT) w_state = ST_HUNT;
                        end
                    end else if (w_word_end) begin
                        w_data_out    = w_cand;
                        w_data_valid  = 1'b1;
                        w_frame_start = (r_word_cnt == 8'd1);
                    end
                end else begin
                    w_state = ST_HUNT;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_HUNT;
            r_sh          <= 32'd0;
            r_bit_cnt     <= 5'd0;
            r_word_cnt    <= 8'd0;
            r_good_cnt    <= 4'd0;
            r_bad_cnt     <= 4'd0;
            r_data_out    <= 32'd0;
            r_data_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_sync_err    <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            if (bus.bit_en) r_sh <= w_cand;
            r_state       <= w_state;
            r_bit_cnt     <= w_bit_cnt;
            r_word_cnt    <= w_word_cnt;
            r_good_cnt    <= w_good_cnt;
            r_bad_cnt     <= w_bad_cnt;
            r_data_out    <= w_data_out;
            r_data_valid  <= w_data_valid;
            r_frame_start <= w_frame_start;
            r_sync_err    <= w_sync_err;
            r_locked      <= (w_state == ST_LOCKED);
        end
    end

`ifdef FRAME_ALIGNER_ERR_CNT_EN
    logic [15:0] r_err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= 16'h0000;
        end else if (w_sync_err && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign bus.err_count = r_err_count;
`else
    assign bus.err_count = 16'h0000;
`endif

    assign bus.data_out    = r_data_out;
    assign bus.data_valid  = r_data_valid;
    assign bus.frame_start = r_frame_start;
    assign bus.locked      = r_locked;
    assign bus.sync_err    = r_sync_err;
endmodule

// File: tb/tb_frame_aligner.sv
// Directed/randomized bench for frame_aligner against a frame-position reference model.
// Honours FRAME_ALIGNER_ERR_CNT_EN for the expected err_count.
module tb_frame_aligner;
    localparam logic [31:0] SYNC = 32'hA5A5_5AF0;
    localparam int FW  = 8;
    localparam int LCK = 2;
    localparam int ULK = 3;
`ifdef FRAME_ALIGNER_ERR_CNT_EN
    localparam logic [15:0] EXP_ERR5 = 16'd5;
`else
    localparam logic [15:0] EXP_ERR5 = 16'd0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_aligner_if bus ();
    frame_aligner dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int failures = 0;
    int n_valid, n_fs, n_serr, n_syncdata, n_lockcyc;

    // Reference model: position measured in bits since the last hunt hit.
    int          m_mode;  // 0 hunt, 1 verify, 2 locked
    logic [31:0] m_win;
    int          m_k, m_good, m_bad;
    logic [31:0] m_data;
    logic        m_valid, m_fs, m_serr, m_locked;
    logic [15:0] m_err;

    function automatic void model_reset();
        m_mode = 0; m_win = 32'd0; m_k = 0; m_good = 0; m_bad = 0;
        m_data = 32'd0; m_valid = 1'b0; m_fs = 1'b0; m_serr = 1'b0;
        m_locked = 1'b0; m_err = 16'd0;
    endfunction

    function automatic void model_bit(input logic b);
        int w;
        m_valid = 1'b0; m_fs = 1'b0; m_serr = 1'b0;
        m_win = {m_win[30:0], b};
        if (m_mode == 0) begin
            if (m_win == SYNC) begin
                m_k = 0; m_good = 1; m_bad = 0;
                m_mode = (LCK == 1) ? 2 : 1;
            end
        end else begin
            m_k++;
            if (m_k % 32 == 0) begin
                w = (m_k / 32) % (FW + 1);
                if (w != 0) begin
                    if (m_mode == 2) begin
                        m_valid = 1'b1; m_fs = (w == 1); m_data = m_win;
                    end
                end else if (m_mode == 1) begin
                    if (m_win == SYNC) begin
                        m_good++;
                        if (m_good >= LCK) begin m_mode = 2; m_bad = 0; end
                    end else begin
                        m_mode = 0; m_good = 0;
                    end
                end else if (m_win == SYNC) begin
                    m_bad = 0;
                end else begin
                    m_serr = 1'b1;
                    m_bad++;
`ifdef FRAME_ALIGNER_ERR_CNT_EN
                    if (m_err != 16'hFFFF) m_err++;
`endif
                    if (m_bad >= ULK) m_mode = 0;
                end
            end
        end
        m_locked = (m_mode == 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".data_out"}, bus.data_out, 32'd0);
        chk({tag, ".data_valid"}, 32'(bus.data_valid), 32'd0);
        chk({tag, ".frame_start"}, 32'(bus.frame_start), 32'd0);
        chk({tag, ".locked"}, 32'(bus.locked), 32'd0);
        chk({tag, ".sync_err"}, 32'(bus.sync_err), 32'd0);
        chk({tag, ".err_count"}, 32'(bus.err_count), 32'd0);
    endtask

    task automatic cyc(input logic en, input logic b);
        @(negedge clk);
        bus.bit_en = en;
        bus.data_in = b;
        if (en) model_bit(b);
        else begin m_valid = 1'b0; m_fs = 1'b0; m_serr = 1'b0; end
        @(posedge clk);
        #1;
        chk("data_valid", 32'(bus.data_valid), 32'(m_valid));
        chk("frame_start", 32'(bus.frame_start), 32'(m_fs));
        chk("sync_err", 32'(bus.sync_err), 32'(m_serr));
        chk("locked", 32'(bus.locked), 32'(m_locked));
        chk("data_out", bus.data_out, m_data);
        chk("err_count", 32'(bus.err_count), 32'(m_err));
        if (bus.data_valid) begin
            n_valid++;
            if (bus.frame_start) n_fs++;
            if (bus.data_out == SYNC) n_syncdata++;
        end
        if (bus.sync_err) n_serr++;
        if (bus.locked) n_lockcyc++;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 31; i >= 0; i--) begin
            for (int g = 0; g < gap; g++) cyc(1'b0, 1'($urandom));
            cyc(1'b1, w[i]);
        end
    endtask

    task automatic send_junk(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'($urandom));
    endtask

    task automatic send_frame(input logic [31:0] sync, input int gap, input bit rnd);
        send_word(sync, gap);
        for (int j = 1; j <= FW; j++) send_word(rnd ? 32'($urandom) : 32'(j), gap);
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b1;
        bus.bit_en = 1'b0;
        #1;
        chk_zero(tag);
        model_reset();
        n_valid = 0; n_fs = 0; n_serr = 0; n_syncdata = 0; n_lockcyc = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] bad;
        rst = 1'b1;
        bus.bit_en = 1'b0;
        bus.data_in = 1'b0;
        #2;
        chk_zero("por");
        model_reset();
        n_valid = 0; n_fs = 0; n_serr = 0; n_syncdata = 0; n_lockcyc = 0;
        @(negedge clk);
        rst = 1'b0;

        // Lock with contiguous bit_en.
        send_junk(5);
        for (int f = 0; f < 3; f++) send_frame(SYNC, 0, 1'b0);
        chk("lock.valid_count", 32'(n_valid), 32'd16);
        chk("lock.fs_count", 32'(n_fs), 32'd2);
        chk("lock.locked_end", 32'(bus.locked), 32'd1);

        // Same stream, bit_en every third cycle.
        do_reset("gap_rst");
        send_junk(5);
        for (int f = 0; f < 3; f++) send_frame(SYNC, 2, 1'b0);
        chk("gap.valid_count", 32'(n_valid), 32'd16);
        chk("gap.fs_count", 32'(n_fs), 32'd2);

        // Sync pattern inside payload is plain data.
        do_reset("false_rst");
        send_junk(5);
        send_frame(SYNC, 0, 1'b1);
        send_frame(SYNC, 0, 1'b1);
        send_word(SYNC, 0);
        send_word(32'($urandom), 0);
        send_word(32'($urandom), 0);
        send_word(SYNC, 0);
        for (int j = 4; j <= FW; j++) send_word(32'($urandom), 0);
        send_frame(SYNC, 0, 1'b1);
        chk("false.sync_as_data", 32'(n_syncdata), 32'd1);
        chk("false.valid_count", 32'(n_valid), 32'd24);
        chk("false.locked_end", 32'(bus.locked), 32'd1);

        // Flywheel: 2 bad, 1 good, 3 bad sync slots.
        do_reset("fly_rst");
        send_junk(7);
        send_frame(SYNC, 0, 1'b1);
        send_frame(SYNC, 0, 1'b1);
        for (int f = 0; f < 6; f++) begin
            bad = SYNC ^ (32'd1 << $urandom_range(31, 0));
            send_frame((f == 2) ? SYNC : bad, 0, 1'b1);
        end
        chk("fly.sync_err_count", 32'(n_serr), 32'd5);
        chk("fly.valid_count", 32'(n_valid), 32'd48);
        chk("fly.locked_end", 32'(bus.locked), 32'd0);
        chk("fly.err_count", 32'(bus.err_count), 32'(EXP_ERR5));

        // Verify failure.
        do_reset("ver_rst");
        send_junk(3);
        send_frame(SYNC, 0, 1'b1);
        send_frame(~SYNC, 0, 1'b1);
        chk("verify.valid_count", 32'(n_valid), 32'd0);
        chk("verify.lock_cycles", 32'(n_lockcyc), 32'd0);

        // Reset at bit 17 of payload word 4, then re-lock from scratch.
        do_reset("mid_pre_rst");
        send_junk(5);
        send_frame(SYNC, 0, 1'b0);
        send_word(SYNC, 0);
        for (int j = 1; j <= 3; j++) send_word(32'(j), 0);
        for (int i = 31; i > 14; i--) cyc(1'b1, 1'($urandom));
        chk("mid.locked_before", 32'(bus.locked), 32'd1);
        do_reset("mid_rst");
        send_frame(SYNC, 0, 1'b0);
        chk("mid.relock_pending", 32'(bus.locked), 32'd0);
        send_word(SYNC, 0);
        chk("mid.relocked", 32'(bus.locked), 32'd1);
        send_frame(SYNC, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
